// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encoding and width helpers for the reset sequencer.
package rst_seq_pkg;
  typedef enum logic [1:0] {HOLD, WAIT, GAP, RUN} rst_seq_state_e;
  function automatic int cnt_width(int h, int g, int t);
    int m;
    m = h > g ? h : g;
    m = m > t ? m : t;
    return $clog2(m) + 1;
  endfunction
  function automatic int idx_width(int n);
    return $clog2(n) + 1;
  endfunction
endpackage

// File: rtl/rst_seq_cnt.sv
// rst_seq_cnt: loadable down-counter that parks at zero and flags it.
module rst_seq_cnt #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= RST_VAL;
    else cnt <= load ? load_val : zero ? cnt : cnt - W'(1);
endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: releases N reset domains in index order, each gated on the
// previous domain's init_done (or a timeout), with software warm-reset replay.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_DOMAINS    = 4,
  parameter int HOLD_CYCLES  = 16,
  parameter int STAGE_GAP    = 8,
  parameter int INIT_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sw_rst_req,
  input  logic [N_DOMAINS-1:0]         init_done,
  output logic [N_DOMAINS-1:0]         rst_out,
  output logic                         seq_done,
  output logic [$clog2(N_DOMAINS):0]   cur_stage,
  output logic                         timeout_err,
  output logic [$clog2(N_DOMAINS):0]   timeout_dom
);
  localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP, INIT_TIMEOUT);
  localparam int IW = idx_width(N_DOMAINS);
  rst_seq_state_e state;
  logic [N_DOMAINS-1:0] sel;
  logic done_i, last, zero, cnt_load;
  logic [CW-1:0] cnt_val;
  always_comb begin
    sel = N_DOMAINS'(1) << cur_stage;
    done_i = |(init_done & sel);
    last = cur_stage == IW'(N_DOMAINS - 1);
    cnt_load = sw_rst_req | (state == HOLD && zero) | (state == WAIT && (done_i || zero))
             | (state == GAP && zero);
    cnt_val = sw_rst_req ? CW'(HOLD_CYCLES - 1) :
              state == WAIT ? CW'(STAGE_GAP - 1) : CW'(INIT_TIMEOUT - 1);
  end
  rst_seq_cnt #(.W(CW), .RST_VAL(CW'(HOLD_CYCLES - 1))) u_cnt (
    .clk(clk), .rst(rst), .load(cnt_load), .load_val(cnt_val), .zero(zero)
  );
  // Releasing a domain is a left shift, which keeps rst_out monotonic by construction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HOLD;
      rst_out <= '1;
      seq_done <= 1'b0;
      cur_stage <= '0;
      timeout_err <= 1'b0;
      timeout_dom <= '0;
    end else if (sw_rst_req) begin
      state <= HOLD;
      rst_out <= '1;
      seq_done <= 1'b0;
      cur_stage <= '0;
    end else begin
      case (state)
        HOLD: if (zero) begin
          rst_out <= rst_out << 1;
          state <= WAIT;
        end
        WAIT: if (done_i || zero) begin
          if (!done_i) begin
            timeout_err <= 1'b1;
            if (!timeout_err) timeout_dom <= cur_stage;
          end
          if (last) begin
            state <= RUN;
            seq_done <= 1'b1;
            cur_stage <= IW'(N_DOMAINS);
          end else state <= GAP;
        end
        GAP: if (zero) begin
          rst_out <= rst_out << 1;
          cur_stage <= cur_stage + IW'(1);
          state <= WAIT;
        end
        RUN: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed checks of release timing, timeout, warm reset and async reset.
module tb_rst_sequencer;
  logic clk = 0, rst = 1, sw_rst_req = 0;
  logic [3:0] init_done = '0, rst_out;
  logic seq_done, timeout_err, mono_bad = 0;
  logic [2:0] cur_stage, timeout_dom;
  int n_chk = 0, n_err = 0, ed = 0;
  rst_sequencer #(.N_DOMAINS(4), .HOLD_CYCLES(16), .STAGE_GAP(8), .INIT_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req), .init_done(init_done), .rst_out(rst_out),
    .seq_done(seq_done), .cur_stage(cur_stage), .timeout_err(timeout_err), .timeout_dom(timeout_dom)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    for (int i = 0; i < 3; i++) if (rst_out[i] && !rst_out[i+1]) mono_bad <= 1'b1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, ed, got, exp);
    end
  endtask
  task automatic go(input int k);
    while (ed < k) begin
      @(posedge clk);
      ed++;
    end
    #1;
  endtask
  task automatic chk_rst_vals(input string tag);
    chk({tag, "_rst_out"}, rst_out, 15);
    chk({tag, "_seq_done"}, seq_done, 0);
    chk({tag, "_cur_stage"}, cur_stage, 0);
    chk({tag, "_terr"}, timeout_err, 0);
    chk({tag, "_tdom"}, timeout_dom, 0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_rst_vals("reset");
    init_done = '1;
    @(negedge clk) rst = 0;
    ed = 0;
    go(15); chk("t1_hold15", rst_out, 15);
    go(16); chk("t1_rel0", rst_out, 14);
    go(24); chk("t1_pre1", rst_out, 14);
    go(25); chk("t1_rel1", rst_out, 12); chk("t1_stage1", cur_stage, 1);
    go(34); chk("t1_rel2", rst_out, 8);
    go(43); chk("t1_rel3", rst_out, 0); chk("t1_stage3", cur_stage, 3); chk("t1_notdone", seq_done, 0);
    go(44); chk("t1_done", seq_done, 1); chk("t1_stage4", cur_stage, 4); chk("t1_terr", timeout_err, 0);
    go(46);
    rst = 1;
    init_done = 4'b0101;
    @(negedge clk) rst = 0;
    ed = 0;
    go(16); chk("t2_rel0", rst_out, 14);
    go(25); chk("t2_rel1", rst_out, 12);
    go(30); init_done = 4'b1101;
    go(31); chk("t6_rst_out", rst_out, 12); chk("t6_stage", cur_stage, 1);
    init_done = 4'b0101;
    go(88); chk("t2_noterr88", timeout_err, 0); chk("t2_hold88", rst_out, 12);
    go(89); chk("t2_terr", timeout_err, 1); chk("t2_tdom", timeout_dom, 1);
    go(96); chk("t2_gap96", rst_out, 12);
    go(97); chk("t2_rel2", rst_out, 8); chk("t2_stage2", cur_stage, 2);
    init_done = 4'b1101;
    go(106); chk("t2_rel3", rst_out, 0); chk("t2_stage3", cur_stage, 3);
    go(107); chk("t2_done", seq_done, 1); chk("t2_stage4", cur_stage, 4);
    go(110); sw_rst_req = 1;
    go(111);
    chk("t3_rst_out", rst_out, 15); chk("t3_seq_done", seq_done, 0); chk("t3_stage", cur_stage, 0);
    chk("t3_terr_kept", timeout_err, 1); chk("t3_tdom_kept", timeout_dom, 1);
    sw_rst_req = 0;
    init_done = '1;
    ed = 0;
    go(15); chk("t3_hold15", rst_out, 15);
    go(16); chk("t3_rel0", rst_out, 14);
    go(44); chk("t3_done", seq_done, 1); chk("t3_stage4", cur_stage, 4); chk("t3_terr", timeout_err, 1);
    go(46); sw_rst_req = 1; init_done = 4'b0011;
    go(47); sw_rst_req = 0;
    ed = 0;
    go(34); chk("t4_rel2", rst_out, 8); chk("t4_stage2", cur_stage, 2);
    go(40); sw_rst_req = 1; init_done = 4'b0111;
    go(41); chk("t4_rst_out", rst_out, 15); chk("t4_stage", cur_stage, 0);
    sw_rst_req = 0;
    ed = 0;
    go(9); chk("t4_no_gap", rst_out, 15);
    sw_rst_req = 1;
    go(10); sw_rst_req = 0; init_done = '1;
    ed = 0;
    go(15); chk("hold_restart15", rst_out, 15);
    go(16); chk("hold_restart16", rst_out, 14);
    go(30); chk("t5_pre_rst_out", rst_out, 12); chk("t5_pre_stage", cur_stage, 1);
    #2 rst = 1;
    #1 chk_rst_vals("t5_async");
    @(negedge clk) rst = 0;
    ed = 0;
    go(15); chk("t5_hold15", rst_out, 15);
    go(16); chk("t5_rel0", rst_out, 14);
    go(43); chk("t5_rel3", rst_out, 0);
    go(44); chk("t5_done", seq_done, 1); chk("t5_stage4", cur_stage, 4);
    chk("monotonic", mono_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
